// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
// Two-master AHB-Lite arbiter placed in front of the uncore. Master 0 is the
// core and master 1 is the DMA/debug master. The block owns the shared address
// phase, tracks which master owns the data phase, routes per-master
// HREADY/HRESP and the write data, and keeps bursts and locked sequences
// atomic.
//
// Ports
//   HCLK, HRESETn           bus clock, asynchronous active-low reset
//   MxHADDR..MxHMASTLOCK    master x address-phase request (x = 0, 1)
//   MxHWDATA, MxHWSTRB      master x data-phase write data / strobes
//   MxHREADY, MxHRESP       per-master ready / response
//   HADDR..HMASTLOCK        muxed address phase to the uncore
//   HWDATA, HWSTRB          muxed data phase to the uncore
//   HREADY, HRESP           slave ready / response
//   HRDATA                  read data (broadcast to the masters outside)
//   Grant                   current address-phase owner
// ---------------------------------------------------------------------------
module ahb_master_arbiter #(
   parameter int unsigned PA_BITS = 32,
   parameter int unsigned AHBW    = 64
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,

   input  logic [PA_BITS-1:0]   M0HADDR,
   input  logic [1:0]           M0HTRANS,
   input  logic                 M0HWRITE,
   input  logic [2:0]           M0HSIZE,
   input  logic [2:0]           M0HBURST,
   input  logic [3:0]           M0HPROT,
   input  logic                 M0HMASTLOCK,
   input  logic [AHBW-1:0]      M0HWDATA,
   input  logic [AHBW/8-1:0]    M0HWSTRB,
   output logic                 M0HREADY,
   output logic                 M0HRESP,

   input  logic [PA_BITS-1:0]   M1HADDR,
   input  logic [1:0]           M1HTRANS,
   input  logic                 M1HWRITE,
   input  logic [2:0]           M1HSIZE,
   input  logic [2:0]           M1HBURST,
   input  logic [3:0]           M1HPROT,
   input  logic                 M1HMASTLOCK,
   input  logic [AHBW-1:0]      M1HWDATA,
   input  logic [AHBW/8-1:0]    M1HWSTRB,
   output logic                 M1HREADY,
   output logic                 M1HRESP,

   output logic [PA_BITS-1:0]   HADDR,
   output logic [1:0]           HTRANS,
   output logic                 HWRITE,
   output logic [2:0]           HSIZE,
   output logic [2:0]           HBURST,
   output logic [3:0]           HPROT,
   output logic                 HMASTLOCK,
   output logic [AHBW-1:0]      HWDATA,
   output logic [AHBW/8-1:0]    HWSTRB,

   input  logic                 HREADY,
   input  logic                 HRESP,
   input  logic [AHBW-1:0]      HRDATA,

   output logic                 Grant
);

   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;
   localparam logic [2:0] BU_WRAP4  = 3'b010;
   localparam logic [2:0] BU_INCR4  = 3'b011;
   localparam logic [1:0] BEATS_4   = 2'd3;

   logic       r_addr_owner;
   logic       r_data_owner;
   logic       r_data_valid;
   logic       r_last_grant;
   logic [1:0] r_beats_left;

   logic       w_accept;
   logic       w_accept_nseq;
   logic       w_accept_seq;
   logic [1:0] w_beats_nxt;
   logic       w_req0;
   logic       w_req1;
   logic       w_hold;
   logic       w_last_eff;
   logic       w_grant_nxt;
   logic       w_m0_dphase;
   logic       w_m1_dphase;
   logic       w_unused_hrdata;

   // Read data is broadcast to both masters outside this block.
   assign w_unused_hrdata = ^HRDATA;

   // Address phase follows the current owner with zero latency.
   assign HADDR     = r_addr_owner ? M1HADDR     : M0HADDR;
   assign HTRANS    = r_addr_owner ? M1HTRANS    : M0HTRANS;
   assign HWRITE    = r_addr_owner ? M1HWRITE    : M0HWRITE;
   assign HSIZE     = r_addr_owner ? M1HSIZE     : M0HSIZE;
   assign HBURST    = r_addr_owner ? M1HBURST    : M0HBURST;
   assign HPROT     = r_addr_owner ? M1HPROT     : M0HPROT;
   assign HMASTLOCK = r_addr_owner ? M1HMASTLOCK : M0HMASTLOCK;
   assign Grant     = r_addr_owner;

   // Data phase follows whoever owned the previously accepted address phase.
   assign HWDATA = r_data_owner ? M1HWDATA : M0HWDATA;
   assign HWSTRB = r_data_owner ? M1HWSTRB : M0HWSTRB;

   assign w_accept      = HREADY & HTRANS[1];
   assign w_accept_nseq = HREADY & (HTRANS == TR_NONSEQ);
   assign w_accept_seq  = HREADY & (HTRANS == TR_SEQ);

   assign w_req0 = (M0HTRANS == TR_NONSEQ);
   assign w_req1 = (M1HTRANS == TR_NONSEQ);

   // Remaining burst beats after this edge; an error response abandons the
   // rest of the burst so the bus can be released.
   always_comb begin
      w_beats_nxt = r_beats_left;
      if (w_accept_nseq) begin
         w_beats_nxt = ((HBURST == BU_WRAP4) || (HBURST == BU_INCR4)) ? BEATS_4 : 2'd0;
      end else if (w_accept_seq && (r_beats_left != 2'd0)) begin
         w_beats_nxt = r_beats_left - 2'd1;
      end
      if (HRESP) begin
         w_beats_nxt = 2'd0;
      end
   end

   assign w_hold = (w_beats_nxt != 2'd0) | HMASTLOCK | (HTRANS == TR_BUSY);

   // A NONSEQ accepted on this very edge counts as the most recent grant, so
   // a master re-requesting right after its own single yields to the other.
   assign w_last_eff = w_accept_nseq ? r_addr_owner : r_last_grant;

   // Round-robin between requesters; park on the current owner when idle.
   always_comb begin
      w_grant_nxt = r_addr_owner;
      if (!w_hold) begin
         if (w_req0 && !w_req1) begin
            w_grant_nxt = 1'b0;
         end else if (w_req1 && !w_req0) begin
            w_grant_nxt = 1'b1;
         end else if (w_req0 && w_req1) begin
            w_grant_nxt = ~w_last_eff;
         end
      end
   end

   // Arbitration and data-phase tracking advance only on HREADY edges.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_addr_owner <= 1'b0;
         r_data_owner <= 1'b0;
         r_data_valid <= 1'b0;
         r_last_grant <= 1'b1;
         r_beats_left <= 2'd0;
      end else if (HREADY) begin
         r_data_valid <= w_accept;
         if (w_accept) begin
            r_data_owner <= r_addr_owner;
         end
         if (w_accept_nseq) begin
            r_last_grant <= r_addr_owner;
         end
         r_beats_left <= w_beats_nxt;
         r_addr_owner <= w_grant_nxt;
      end
   end

   assign w_m0_dphase = r_data_valid & ~r_data_owner;
   assign w_m1_dphase = r_data_valid &  r_data_owner;

   // A master in its data phase sees the slave's ready directly; otherwise it
   // is ready only as address owner with no other master's data phase open.
   assign M0HREADY = HRESETn &
                     (w_m0_dphase ? HREADY : (HREADY & ~r_addr_owner & ~w_m1_dphase));
   assign M1HREADY = HRESETn &
                     (w_m1_dphase ? HREADY : (HREADY &  r_addr_owner & ~w_m0_dphase));

   assign M0HRESP = HRESP & w_m0_dphase;
   assign M1HRESP = HRESP & w_m1_dphase;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_arbiter
// Directed bench for ahb_master_arbiter. A transaction-level model tracks
// owner, data-phase owner, remaining beats and the round-robin pointer as
// plain variables; every cycle the DUT outputs are checked against it, and
// hand-computed literals pin the key cycles of each scenario.
// ---------------------------------------------------------------------------
module tb_ahb_master_arbiter;

   localparam int unsigned PA_BITS = 32;
   localparam int unsigned AHBW    = 64;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NS   = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;
   localparam logic [2:0] B_SINGLE = 3'b000;
   localparam logic [2:0] B_WRAP4  = 3'b010;
   localparam logic [2:0] B_INCR4  = 3'b011;

   localparam logic [63:0] W0 = 64'hA0A0_0000_0000_A0A0;
   localparam logic [63:0] W1 = 64'hB1B1_1111_1111_B1B1;
   localparam logic [7:0]  S0 = 8'hFF;
   localparam logic [7:0]  S1 = 8'h0F;

   typedef struct {
      logic [1:0]  t;
      logic [31:0] a;
      logic [2:0]  b;
      logic        l;
      logic        w;
   } mst_t;

   logic HCLK = 1'b0;
   logic HRESETn;
   logic rdy, rsp;
   mst_t m [2];

   logic [PA_BITS-1:0] M0HADDR, M1HADDR, HADDR;
   logic [1:0]  M0HTRANS, M1HTRANS, HTRANS;
   logic        M0HWRITE, M1HWRITE, HWRITE;
   logic [2:0]  M0HSIZE, M1HSIZE, HSIZE, M0HBURST, M1HBURST, HBURST;
   logic [3:0]  M0HPROT, M1HPROT, HPROT;
   logic        M0HMASTLOCK, M1HMASTLOCK, HMASTLOCK;
   logic [AHBW-1:0]   M0HWDATA, M1HWDATA, HWDATA, HRDATA;
   logic [AHBW/8-1:0] M0HWSTRB, M1HWSTRB, HWSTRB;
   logic M0HREADY, M1HREADY, M0HRESP, M1HRESP, HREADY, HRESP, Grant;

   always #5 HCLK = ~HCLK;

   assign M0HADDR = m[0].a;  assign M1HADDR = m[1].a;
   assign M0HTRANS = m[0].t; assign M1HTRANS = m[1].t;
   assign M0HBURST = m[0].b; assign M1HBURST = m[1].b;
   assign M0HMASTLOCK = m[0].l; assign M1HMASTLOCK = m[1].l;
   assign M0HWRITE = m[0].w; assign M1HWRITE = m[1].w;
   assign M0HSIZE = 3'd3;    assign M1HSIZE = 3'd2;
   assign M0HPROT = 4'h3;    assign M1HPROT = 4'hA;
   assign M0HWDATA = W0;     assign M1HWDATA = W1;
   assign M0HWSTRB = S0;     assign M1HWSTRB = S1;
   assign HREADY = rdy;
   assign HRESP  = rsp;
   assign HRDATA = 64'h0;

   ahb_master_arbiter #(.PA_BITS(PA_BITS), .AHBW(AHBW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .M0HADDR(M0HADDR), .M0HTRANS(M0HTRANS), .M0HWRITE(M0HWRITE),
      .M0HSIZE(M0HSIZE), .M0HBURST(M0HBURST), .M0HPROT(M0HPROT),
      .M0HMASTLOCK(M0HMASTLOCK), .M0HWDATA(M0HWDATA), .M0HWSTRB(M0HWSTRB),
      .M0HREADY(M0HREADY), .M0HRESP(M0HRESP),
      .M1HADDR(M1HADDR), .M1HTRANS(M1HTRANS), .M1HWRITE(M1HWRITE),
      .M1HSIZE(M1HSIZE), .M1HBURST(M1HBURST), .M1HPROT(M1HPROT),
      .M1HMASTLOCK(M1HMASTLOCK), .M1HWDATA(M1HWDATA), .M1HWSTRB(M1HWSTRB),
      .M1HREADY(M1HREADY), .M1HRESP(M1HRESP),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
      .HWDATA(HWDATA), .HWSTRB(HWSTRB),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .Grant(Grant)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Model state: who owns each phase, beats still owed, last master served.
   bit mo_ao, mo_do, mo_dv, mo_last;
   int mo_beats;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic set_m(input int x, input logic [1:0] t, input logic [31:0] a,
                        input logic [2:0] b, input logic l, input logic w);
      m[x].t = t; m[x].a = a; m[x].b = b; m[x].l = l; m[x].w = w;
   endtask

   task automatic idle_m(input int x);
      set_m(x, T_IDLE, 32'h0, B_SINGLE, 1'b0, 1'b0);
   endtask

   task automatic model_reset();
      mo_ao = 1'b0; mo_do = 1'b0; mo_dv = 1'b0; mo_last = 1'b1; mo_beats = 0;
   endtask

   // Compare every DUT output with what the model says it must be now.
   task automatic model_check();
      bit a;
      bit mine, other;
      logic exp_rdy, exp_rsp, act_rdy, act_rsp;
      a = mo_ao;
      chk("haddr",  64'(HADDR),     64'(m[a].a));
      chk("htrans", 64'(HTRANS),    64'(m[a].t));
      chk("hburst", 64'(HBURST),    64'(m[a].b));
      chk("hlock",  64'(HMASTLOCK), 64'(m[a].l));
      chk("hwrite", 64'(HWRITE),    64'(m[a].w));
      chk("hsize",  64'(HSIZE),     a ? 64'd2 : 64'd3);
      chk("hprot",  64'(HPROT),     a ? 64'hA : 64'h3);
      chk("grant",  64'(Grant),     64'(a));
      chk("hwdata", HWDATA,         mo_do ? W1 : W0);
      chk("hwstrb", 64'(HWSTRB),    mo_do ? 64'(S1) : 64'(S0));
      for (int x = 0; x < 2; x++) begin
         mine    = mo_dv && (int'(mo_do) == x);
         other   = mo_dv && (int'(mo_do) != x);
         exp_rdy = !HRESETn ? 1'b0 : (mine ? rdy : (rdy && (int'(a) == x) && !other));
         exp_rsp = rsp && mine;
         act_rdy = (x == 1) ? M1HREADY : M0HREADY;
         act_rsp = (x == 1) ? M1HRESP  : M0HRESP;
         chk(x == 1 ? "m1hready" : "m0hready", 64'(act_rdy), 64'(exp_rdy));
         chk(x == 1 ? "m1hresp"  : "m0hresp",  64'(act_rsp), 64'(exp_rsp));
      end
   endtask

   // Advance the model across one rising edge using the inputs of the cycle.
   task automatic model_edge();
      bit a, acc, nsq, w, found;
      int nb, last, c;
      if (!HRESETn || !rdy) return;
      a   = mo_ao;
      acc = (m[a].t == T_NS) || (m[a].t == T_SEQ);
      nsq = (m[a].t == T_NS);
      nb  = mo_beats;
      if (nsq) nb = ((m[a].b == B_WRAP4) || (m[a].b == B_INCR4)) ? 3 : 0;
      else if (acc) nb = (nb > 0) ? nb - 1 : 0;
      if (rsp) nb = 0;
      w = a;
      if (nb == 0 && !m[a].l && m[a].t != T_BUSY) begin
         last  = nsq ? int'(a) : int'(mo_last);
         found = 1'b0;
         for (int k = 1; k <= 2; k++) begin
            c = (last + k) % 2;
            if (!found && m[c].t == T_NS) begin
               w = 1'(c);
               found = 1'b1;
            end
         end
      end
      mo_dv = acc;
      if (acc) mo_do = a;
      if (nsq) mo_last = a;
      mo_beats = nb;
      mo_ao = w;
   endtask

   task automatic cyc_begin();
      #1;
      model_check();
   endtask

   task automatic cyc_end();
      @(posedge HCLK);
      model_edge();
      @(negedge HCLK);
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      model_reset();
      idle_m(0); idle_m(1);
      rdy = 1'b1; rsp = 1'b0;
      cyc_begin();
      chk("rst_m0hready", 64'(M0HREADY), 64'd0);
      chk("rst_m1hready", 64'(M1HREADY), 64'd0);
      chk("rst_grant",    64'(Grant),    64'd0);
      cyc_end();
      HRESETn = 1'b1;
   endtask

   int cnt [2];

   initial begin
      // 1: single read by the core right after reset
      do_reset();
      set_m(0, T_NS, 32'h8000_0000, B_SINGLE, 1'b0, 1'b0);
      cyc_begin();
      chk("t1_haddr",    64'(HADDR),    64'h8000_0000);
      chk("t1_m0hready", 64'(M0HREADY), 64'd1);
      chk("t1_m1hready", 64'(M1HREADY), 64'd0);
      cyc_end();
      idle_m(0);
      cyc_begin();
      chk("t1_dphase_rdy", 64'(M0HREADY), 64'd1);
      chk("t1_dphase_wd",  HWDATA,        W0);
      chk("t1_m1hready2",  64'(M1HREADY), 64'd0);
      cyc_end();

      // 2: both masters request singles continuously
      do_reset();
      cnt[0] = 0; cnt[1] = 0;
      for (int i = 0; i < 4; i++) begin
         set_m(0, T_NS, 32'h100, B_SINGLE, 1'b0, 1'b0);
         set_m(1, T_NS, 32'h200, B_SINGLE, 1'b0, 1'b0);
         cyc_begin();
         chk("t2_grant", 64'(Grant), 64'(i % 2));
         chk("t2_haddr", 64'(HADDR), (i % 2 == 1) ? 64'h200 : 64'h100);
         cnt[Grant]++;
         cyc_end();
      end
      chk("t2_cnt0", 64'(cnt[0]), 64'd2);
      chk("t2_cnt1", 64'(cnt[1]), 64'd2);

      // 3: INCR4 write by the core while master 1 waits
      do_reset();
      set_m(1, T_NS, 32'h2000, B_SINGLE, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_m(0, (i == 0) ? T_NS : T_SEQ, 32'h1000 + 32'(8 * i), B_INCR4, 1'b0, 1'b1);
         cyc_begin();
         chk("t3_grant", 64'(Grant), 64'd0);
         chk("t3_haddr", 64'(HADDR), 64'h1000 + 64'(8 * i));
         if (i > 0) chk("t3_wdata", HWDATA, W0);
         cyc_end();
      end
      idle_m(0);
      cyc_begin();
      chk("t3_grant_m1", 64'(Grant),    64'd1);
      chk("t3_haddr_m1", 64'(HADDR),    64'h2000);
      chk("t3_wdata4",   HWDATA,        W0);
      chk("t3_m1hready", 64'(M1HREADY), 64'd0);
      cyc_end();
      idle_m(1);
      cyc_begin();
      chk("t3_wdata_m1", HWDATA, W1);
      cyc_end();

      // 4: locked pair of singles by master 1
      do_reset();
      set_m(1, T_NS, 32'h300, B_SINGLE, 1'b1, 1'b0);
      cyc_begin();
      chk("t4_grant0", 64'(Grant), 64'd0);
      cyc_end();
      set_m(0, T_NS, 32'h400, B_SINGLE, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i < 2) set_m(1, T_NS, 32'h300 + 32'(4 * i), B_SINGLE, 1'b1, 1'b0);
         else idle_m(1);
         cyc_begin();
         chk("t4_grant_m1", 64'(Grant),    64'd1);
         chk("t4_m0wait",   64'(M0HREADY), 64'd0);
         cyc_end();
      end
      cyc_begin();
      chk("t4_grant_m0", 64'(Grant),    64'd0);
      chk("t4_haddr_m0", 64'(HADDR),    64'h400);
      chk("t4_m0hready", 64'(M0HREADY), 64'd1);
      cyc_end();

      // 5: master 1 read with three wait states then an error
      do_reset();
      set_m(1, T_NS, 32'h500, B_SINGLE, 1'b0, 1'b0);
      cyc_begin(); cyc_end();
      cyc_begin();
      chk("t5_grant1",  64'(Grant),    64'd1);
      chk("t5_m1ready", 64'(M1HREADY), 64'd1);
      cyc_end();
      idle_m(1);
      set_m(0, T_NS, 32'h600, B_SINGLE, 1'b0, 1'b0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc_begin();
         chk("t5_m1wait",  64'(M1HREADY), 64'd0);
         chk("t5_m0stall", 64'(M0HREADY), 64'd0);
         cyc_end();
      end
      rsp = 1'b1;
      cyc_begin();
      chk("t5_m1resp",  64'(M1HRESP), 64'd1);
      chk("t5_m0resp",  64'(M0HRESP), 64'd0);
      cyc_end();
      rdy = 1'b1;
      cyc_begin();
      chk("t5_m1resp2", 64'(M1HRESP),  64'd1);
      chk("t5_m1rdy2",  64'(M1HREADY), 64'd1);
      chk("t5_m0resp2", 64'(M0HRESP),  64'd0);
      cyc_end();
      rsp = 1'b0;
      cyc_begin();
      chk("t5_grant0",  64'(Grant), 64'd0);
      chk("t5_haddr0",  64'(HADDR), 64'h600);
      cyc_end();

      // 7: error mid-burst releases the bus early
      do_reset();
      set_m(0, T_NS, 32'h900, B_INCR4, 1'b0, 1'b0);
      set_m(1, T_NS, 32'hA00, B_SINGLE, 1'b0, 1'b0);
      cyc_begin(); cyc_end();
      set_m(0, T_SEQ, 32'h908, B_INCR4, 1'b0, 1'b0);
      rdy = 1'b0; rsp = 1'b1;
      cyc_begin();
      chk("t7_m0resp", 64'(M0HRESP), 64'd1);
      chk("t7_m1resp", 64'(M1HRESP), 64'd0);
      cyc_end();
      rdy = 1'b1;
      cyc_begin();
      chk("t7_grant0", 64'(Grant), 64'd0);
      cyc_end();
      idle_m(0); rsp = 1'b0;
      cyc_begin();
      chk("t7_grant1", 64'(Grant), 64'd1);
      chk("t7_haddr1", 64'(HADDR), 64'hA00);
      cyc_end();

      // 6: reset asserted during beat 2 of a WRAP4
      do_reset();
      set_m(0, T_NS, 32'h700, B_WRAP4, 1'b0, 1'b1);
      cyc_begin(); cyc_end();
      set_m(0, T_SEQ, 32'h708, B_WRAP4, 1'b0, 1'b1);
      cyc_begin();
      #1 HRESETn = 1'b0;
      model_reset();
      #1 model_check();
      chk("t6_m0hready", 64'(M0HREADY), 64'd0);
      chk("t6_m1hready", 64'(M1HREADY), 64'd0);
      chk("t6_grant",    64'(Grant),    64'd0);
      chk("t6_haddr",    64'(HADDR),    64'h708);
      cyc_end();
      HRESETn = 1'b1;
      set_m(0, T_NS, 32'h780, B_SINGLE, 1'b0, 1'b0);
      set_m(1, T_NS, 32'h880, B_SINGLE, 1'b0, 1'b0);
      cyc_begin();
      chk("t6_first_m0", 64'(Grant), 64'd0);
      cyc_end();
      cyc_begin();
      chk("t6_then_m1",  64'(Grant), 64'd1);
      chk("t6_haddr_m1", 64'(HADDR), 64'h880);
      cyc_end();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
